// File: rtl/dmd_pkg.sv
// dmd_pkg: shared definitions for the dot-matrix display scanner.
//   DMD_ROWS / DMD_COLS : panel geometry (16x16)
//   ROW_W               : row address width
//   dmd_state_e         : row-scan FSM states, 2-bit encoding
//   max4()              : largest of four phase lengths, used to size the
//                         shared phase counter
package dmd_pkg;

  localparam int DMD_ROWS = 16;
  localparam int DMD_COLS = 16;
  localparam int ROW_W    = 4;

  typedef enum logic [1:0] {
    BLANK = 2'd0,
    SETUP = 2'd1,
    LATCH = 2'd2,
    HOLD  = 2'd3
  } dmd_state_e;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/dmd_framebuf.sv
// dmd_framebuf: two 16x16 pixel buffers, one displayed (front) and one
// written by Main (back).
//   clk, rst_n : clock, asynchronous active-low reset (clears both buffers)
//   front_sel  : 0 = buffer 0 is front, 1 = buffer 1 is front
//   wr_en      : write wr_data into back[wr_row] at the clock edge
//   wr_row     : back-buffer row address
//   wr_data    : row pixels
//   rd_row     : front-buffer row to read
//   rd_data    : front[rd_row], combinational
module dmd_framebuf
  import dmd_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                front_sel,
  input  logic                wr_en,
  input  logic [ROW_W-1:0]    wr_row,
  input  logic [DMD_COLS-1:0] wr_data,
  input  logic [ROW_W-1:0]    rd_row,
  output logic [DMD_COLS-1:0] rd_data
);

  logic [DMD_COLS-1:0] mem0 [DMD_ROWS];
  logic [DMD_COLS-1:0] mem1 [DMD_ROWS];

  // The back buffer is whichever one front_sel does not select at the start
  // of the cycle, so a write on the swap edge lands in the buffer that is
  // about to become front.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DMD_ROWS; i++) begin
        mem0[i] <= '0;
        mem1[i] <= '0;
      end
    end else if (wr_en) begin
      if (front_sel) mem0[wr_row] <= wr_data;
      else           mem1[wr_row] <= wr_data;
    end
  end

  assign rd_data = front_sel ? mem1[rd_row] : mem0[rd_row];

endmodule

// File: rtl/dmd_scanner.sv
// dmd_scanner: row-scans a double-buffered 16x16 frame onto a DMD panel.
// Each row runs BLANK -> SETUP -> LATCH -> HOLD; a front/back swap requested
// by Main is applied only at the end of row 15 so frames never tear.
//   CLK, RESET : clock, asynchronous active-low reset
//   wr_en, wr_row, wr_data : write one back-buffer row
//   swap_req   : pulse, request a swap at the next frame end
//   blank_in   : force DMD_CLR high without disturbing the scan
//   swap_ack   : pulse on the cycle the swap takes effect
//   frame_done : pulse on the first BLANK cycle of row 0
//   DMD_CLR    : 1 = panel blanked (combinational)
//   dmd_seg    : current row select
//   dmd_column : column data for the current row
//   DMD_CLK    : latch strobe
module dmd_scanner
  import dmd_pkg::*;
#(
  parameter int BLANK_CYC = 2,
  parameter int SETUP_CYC = 2,
  parameter int LATCH_CYC = 1,
  parameter int HOLD_CYC  = 64
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                wr_en,
  input  logic [ROW_W-1:0]    wr_row,
  input  logic [DMD_COLS-1:0] wr_data,
  input  logic                swap_req,
  input  logic                blank_in,
  output logic                swap_ack,
  output logic                frame_done,
  output logic                DMD_CLR,
  output logic [ROW_W-1:0]    dmd_seg,
  output logic [DMD_COLS-1:0] dmd_column,
  output logic                DMD_CLK
);

  localparam int MAX_CYC = max4(BLANK_CYC, SETUP_CYC, LATCH_CYC, HOLD_CYC);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);

  dmd_state_e          state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt, cnt_last;
  logic [ROW_W-1:0]    row, row_nxt;
  logic                swap_pending, pend_nxt, pend_eff;
  logic                front_sel, front_nxt;
  logic [ROW_W-1:0]    seg_nxt;
  logic [DMD_COLS-1:0] col_nxt, rd_data;
  logic                clk_nxt, ack_nxt, done_nxt, frame_end;

  dmd_framebuf u_framebuf (
    .clk       (CLK),
    .rst_n     (RESET),
    .front_sel (front_sel),
    .wr_en     (wr_en),
    .wr_row    (wr_row),
    .wr_data   (wr_data),
    .rd_row    (row),
    .rd_data   (rd_data)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state        <= BLANK;
      cnt          <= '0;
      row          <= '0;
      swap_pending <= 1'b0;
      front_sel    <= 1'b0;
      dmd_seg      <= '0;
      dmd_column   <= '0;
      DMD_CLK      <= 1'b0;
      swap_ack     <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      row          <= row_nxt;
      swap_pending <= pend_nxt;
      front_sel    <= front_nxt;
      dmd_seg      <= seg_nxt;
      dmd_column   <= col_nxt;
      DMD_CLK      <= clk_nxt;
      swap_ack     <= ack_nxt;
      frame_done   <= done_nxt;
    end
  end

  // Registered outputs are computed from the next state so they change on
  // the same edge as the state they belong to.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    row_nxt   = row;
    seg_nxt   = dmd_seg;
    col_nxt   = dmd_column;
    frame_end = 1'b0;

    case (state)
      BLANK:   cnt_last = BLANK_LAST;
      SETUP:   cnt_last = SETUP_LAST;
      LATCH:   cnt_last = LATCH_LAST;
      default: cnt_last = HOLD_LAST;
    endcase

    if (cnt == cnt_last) begin
      cnt_nxt = '0;
      case (state)
        BLANK: begin
          state_nxt = SETUP;
          col_nxt   = rd_data;
        end
        SETUP:   state_nxt = LATCH;
        LATCH:   state_nxt = HOLD;
        default: begin
          state_nxt = BLANK;
          row_nxt   = row + ROW_W'(1);
          seg_nxt   = row + ROW_W'(1);
          col_nxt   = '0;
          frame_end = (row == ROW_W'(DMD_ROWS - 1));
        end
      endcase
    end

    clk_nxt = (state_nxt == LATCH);

    // A request arriving on the frame-end cycle itself still swaps now.
    pend_eff  = swap_pending | swap_req;
    front_nxt = front_sel;
    pend_nxt  = pend_eff;
    ack_nxt   = 1'b0;
    done_nxt  = frame_end;
    if (frame_end) begin
      front_nxt = front_sel ^ pend_eff;
      pend_nxt  = 1'b0;
      ack_nxt   = pend_eff;
    end
  end

  assign DMD_CLR = blank_in | (state != HOLD);

endmodule

// File: doc/dmd_scanner.md
Name: dmd_scanner

Overview:
- Downstream display stage of Main. Owns a double-buffered 16x16 dot-matrix frame.
- Main writes whole rows into the back buffer, then requests a swap.
- The block row-scans the front buffer onto the DMD pins: DMD_CLR, dmd_seg, dmd_column, DMD_CLK.
- Swaps occur only at frame boundaries, so the panel never shows a torn frame.

Parameters:
- BLANK_CYC, 2, CLK cycles per row spent blanked with the new row address settling.
- SETUP_CYC, 2, CLK cycles with column data driven before the latch pulse.
- LATCH_CYC, 1, CLK cycles DMD_CLK is held high.
- HOLD_CYC, 64, CLK cycles the row is lit.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- wr_en  in  1  write one row of the back buffer this cycle.
- wr_row  in  4  back-buffer row address.
- wr_data  in  16  row pixel data; bit i maps to dmd_column[i].
- swap_req  in  1  single-cycle pulse requesting a front/back swap at the next frame end.
- blank_in  in  1  forces DMD_CLR=1; scanning continues.
- swap_ack  out  1  one-cycle pulse on the cycle the swap takes effect.
- frame_done  out  1  one-cycle pulse when row 15's HOLD completes.
- DMD_CLR  out  1  1 = panel blanked.
- dmd_seg  out  4  current row select.
- dmd_column  out  16  column data for the current row.
- DMD_CLK  out  1  latch strobe.

Behaviour:
- Clock and reset:
  - Single clock CLK.
  - RESET is asynchronous and active-low.
- Reset values (RESET=0, effective immediately, including mid-operation):
  - Outputs: DMD_CLR=1, dmd_seg=0, dmd_column=0, DMD_CLK=0, swap_ack=0, frame_done=0.
  - State: state=BLANK, row=0, phase counter=0, swap_pending=0, front select=0.
  - Both buffers cleared to 0.
- FSM states BLANK -> SETUP -> LATCH -> HOLD -> BLANK. Each state lasts exactly its *_CYC cycles, counted by one shared counter that reloads on every transition.
  - BLANK: DMD_CLR=1, dmd_column=0, DMD_CLK=0. dmd_seg=row, updated on entry.
  - SETUP: DMD_CLR=1, dmd_column=front[row], DMD_CLK=0.
  - LATCH: as SETUP, with DMD_CLK=1.
  - HOLD: DMD_CLK=0, dmd_column held, DMD_CLR=blank_in.
  - Leaving HOLD: row=row+1, wrapping 15->0.
- Row and frame periods:
  - Row period = BLANK_CYC+SETUP_CYC+LATCH_CYC+HOLD_CYC cycles (69 with defaults).
  - Frame period = 16 x row period.
- blank_in: DMD_CLR = blank_in OR (state != HOLD). This term is combinational, the only combinational output path. All other outputs are registered.
- Writes:
  - When wr_en=1, back[wr_row] <= wr_data at the clock edge.
  - "Back" is the back buffer as selected at the start of that cycle.
  - Writes never affect the front buffer, so the displayed frame is unaffected.
- Swap handshake:
  - swap_req=1 sets swap_pending.
  - Further requests while pending are absorbed; one swap per frame maximum.
- Frame end (last HOLD cycle of row 15):
  - frame_done pulses for 1 cycle on the first BLANK cycle of row 0.
  - If swap_pending: front select flips and swap_pending clears. swap_ack pulses in the same cycle as frame_done.
  - Row 0 of the new frame reads the new front buffer.
- Simultaneous events:
  - swap_req on the same cycle as the frame-end transition is counted as pending before the check, so the swap happens now.
  - A write in the swap cycle lands in the pre-swap back buffer, i.e. the buffer that becomes front. It therefore appears from the next frame onward, since front[row] is sampled in SETUP.
- Width rules:
  - Counters are sized for the maximum parameter value, $clog2(max+1).
  - *_CYC must be >= 1.

Decomposition:
- Shared package dmd_pkg:
  - DMD_ROWS=16, DMD_COLS=16, ROW_W=4.
  - State enum (BLANK, SETUP, LATCH, HOLD), 2-bit encoding.
- Sub-module dmd_framebuf holds the two 16x16 arrays.
  - Inputs: front-select bit, write port, read row.
  - Output: front[row].
  - The scanner FSM, counters and swap logic stay in dmd_scanner.

Test Plan (CYC params 1,1,1,2 -> 5-cycle rows, 80-cycle frames):
- Reset and idle timing: hold RESET=0 -> DMD_CLR=1, dmd_seg=0, dmd_column=0, DMD_CLK=0. After release, DMD_CLK rises on cycle 3 and lasts 1 cycle; dmd_seg steps 0..15 every 5 cycles; frame_done pulses every 80 cycles; dmd_column=0 throughout.
- Write then swap: write row 3=16'hA5A5 and row 15=16'hFFFF, pulse swap_req mid-frame -> swap_ack coincides with the next frame_done, not earlier. In the following frame, dmd_column=16'hA5A5 while dmd_seg=3 during SETUP/LATCH/HOLD, and 16'hFFFF on row 15.
- Double request: pulse swap_req twice in one frame -> exactly one swap_ack; the next frame end shows no swap.
- Boundary collision: swap_req together with wr_en(row 0, 16'h1234) on the frame-end cycle -> swap_ack that cycle; row 0 shows 16'h1234 starting the frame after.
- blank_in: assert during row 5 HOLD -> DMD_CLR=1 immediately; dmd_seg/DMD_CLK sequence unchanged.
- Reset mid-operation: drop RESET in row 9 HOLD with swap pending -> all outputs at reset values asynchronously. After release, scanning restarts at row 0, front is buffer 0 and all zeros, and no swap_ack is emitted.
